fnd_scan_controller: RTL and testbench

Downstream display stage of the 0–9999 counter: takes the 14-bit binary count and drives a 4-digit common-anode 7-segment display (FND) by time-multiplexing. It converts binary to BCD with a sequential double-dabble engine and applies leading-zero blanking. It latches the new value only at frame boundaries, so a digit never tears mid-scan. All logic runs on the system clock; the counter's value is sampled, never used as a clock.

---
 rtl/fnd_pkg.sv | 48 ++++
 rtl/bin2bcd_seq.sv | 75 +++++++
 rtl/fnd_scan_controller.sv | 85 ++++++++
 tb/tb_fnd_scan_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants and types for the 4-digit FND scan display.
//   - Segment codes (active-low, bit0=a .. bit6=g, bit7=dp kept off)
//   - Display geometry and count range
//   - Conversion FSM state type
//   - seg_decode(): BCD digit -> segment code
package fnd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int MAX_COUNT  = 9999;
    localparam int COUNT_W    = 14;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one result every 16 cycles.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   bin       in   14-bit binary input, clamped to 9999 when sampled
//   bcd       out  16-bit BCD result (valid while bcd_valid is high)
//   bcd_valid out  one-cycle pulse while the FSM sits in DONE
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [COUNT_W-1:0]      bin,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    bcd_valid
);

    conv_state_t               r_state;
    logic [COUNT_W-1:0]        r_bin;
    logic [4*NUM_DIGITS-1:0]   r_bcd;
    logic [3:0]                r_iter;
    logic [4*NUM_DIGITS-2:0]   w_adj;
    logic [COUNT_W-1:0]        w_clamped;

    assign w_clamped = (bin > COUNT_W'(MAX_COUNT)) ? COUNT_W'(MAX_COUNT) : bin;

    // Only the low three nibbles ever need the +3 correction: the final
    // thousands digit is at most 9, so before any shift it is at most 4.
    // That also means bit 15 is always zero before a shift and can be dropped.
    always_comb begin
        w_adj = r_bcd[4*NUM_DIGITS-2:0];
        for (int k = 0; k < NUM_DIGITS - 1; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5)
                w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_iter    <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_bin   <= w_clamped;
                    r_bcd   <= '0;
                    r_iter  <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_bcd  <= {w_adj, r_bin[COUNT_W-1]};
                    r_bin  <= {r_bin[COUNT_W-2:0], 1'b0};
                    r_iter <= r_iter + 4'd1;
                    if (r_iter == 4'(COUNT_W - 1)) begin
                        r_state   <= DONE;
                        bcd_valid <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bcd = r_bcd;

endmodule

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: drives a 4-digit common-anode 7-segment display by
// time-multiplexing, with leading-zero blanking and frame-aligned updates.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   count     in   14-bit value to show (values above 9999 show 9999)
//   fnd_data  out  segments, active-low, bit0=a .. bit6=g, bit7=dp (off)
//   fnd_com   out  digit enables, active-low one-hot, [0]=ones .. [3]=thousands
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [COUNT_W-1:0]    count,
    output logic [7:0]            fnd_data,
    output logic [NUM_DIGITS-1:0] fnd_com
);

    localparam int PRESC_W = $clog2(SCAN_DIV);

    logic [PRESC_W-1:0]      r_presc;
    logic [1:0]              r_idx;
    logic [4*NUM_DIGITS-1:0] r_bcd_pending;
    logic [4*NUM_DIGITS-1:0] r_bcd_disp;
    logic                    w_tick;
    logic [4*NUM_DIGITS-1:0] w_bcd;
    logic                    w_bcd_valid;
    logic [3:0]              w_nibble;
    logic                    w_blank;
    logic [7:0]              w_seg;

    bin2bcd_seq u_bin2bcd (
        .clk       (clk),
        .reset     (reset),
        .bin       (count),
        .bcd       (w_bcd),
        .bcd_valid (w_bcd_valid)
    );

    assign w_tick = (r_presc == PRESC_W'(SCAN_DIV - 1));

    // A digit is blank when it and every digit above it are zero; the ones
    // digit always shows so that zero reads "   0".
    always_comb begin
        w_nibble = r_bcd_disp[{r_idx, 2'b00} +: 4];
        case (r_idx)
            2'd1:    w_blank = (r_bcd_disp[15:4]  == 12'd0);
            2'd2:    w_blank = (r_bcd_disp[15:8]  == 8'd0);
            2'd3:    w_blank = (r_bcd_disp[15:12] == 4'd0);
            default: w_blank = 1'b0;
        endcase
        w_seg = w_blank ? SEG_BLANK : seg_decode(w_nibble);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc       <= '0;
            r_idx         <= 2'd0;
            r_bcd_pending <= '0;
            r_bcd_disp    <= '0;
            fnd_com       <= 4'b1110;
            fnd_data      <= SEG_0;
        end else begin
            if (w_bcd_valid)
                r_bcd_pending <= w_bcd;

            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= r_idx + 2'd1;
                // Frame boundary: the only point where the shown value changes,
                // so a frame never mixes digits of two different values.
                if (r_idx == 2'd3)
                    r_bcd_disp <= r_bcd_pending;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            fnd_com  <= ~(4'b0001 << r_idx);
            fnd_data <= w_seg;
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
module tb_fnd_scan_controller;

    localparam int SCAN_DIV = 20;
    localparam int SETTLE   = 4 * SCAN_DIV + 40;

    typedef struct packed {
        logic [3:0] com;
        logic [7:0] data;
    } slot_t;

    logic        clk;
    logic        reset;
    logic [13:0] count;
    logic [7:0]  fnd_data;
    logic [3:0]  fnd_com;

    int    vectors;
    int    miscompares;
    slot_t sb[$];

    fnd_scan_controller #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .count    (count),
        .fnd_data (fnd_data),
        .fnd_com  (fnd_com)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] seg_code(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Expected four slots of one frame for value v, pushed into the scoreboard.
    task automatic push_frame(input int v);
        int vv;
        int p;
        slot_t s;
        vv = (v > 9999) ? 9999 : v;
        p  = 1;
        for (int k = 0; k < 4; k++) begin
            s.com  = ~(4'b0001 << k);
            s.data = (k > 0 && vv < p) ? 8'hFF : seg_code((vv / p) % 10);
            sb.push_back(s);
            p = p * 10;
        end
    endtask

    // Wait for the start of a frame (com goes 0111 -> 1110), sampled on negedge.
    task automatic sync_frame();
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        prev  = fnd_com;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (fnd_com == 4'b1110 && prev == 4'b0111) found = 1'b1;
            prev = fnd_com;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL frame_sync: no frame start seen, com=%b required wrap to 1110", fnd_com);
        end
    endtask

    // Called at the first negedge of a slot; returns its com/data and length,
    // leaving the caller at the first negedge of the next slot.
    task automatic capture_slot(output logic [3:0] c, output logic [7:0] d, output int len);
        bit done;
        c    = fnd_com;
        d    = fnd_data;
        len  = 1;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (fnd_com !== c) done = 1'b1;
            else len++;
        end
    endtask

    task automatic test_reset();
        bit bad_early;
        count = 14'd1234;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (fnd_com !== 4'b1110 || fnd_data !== 8'hC0) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: com=%b data=%h required com=1110 data=c0", i, fnd_com, fnd_data);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (fnd_com !== 4'b1110 || fnd_data !== 8'hC0) begin
            miscompares++;
            $display("FAIL reset_after: com=%b data=%h required com=1110 data=c0", fnd_com, fnd_data);
        end
        bad_early = 1'b0;
        for (int i = 0; i < SCAN_DIV - 2; i++) begin
            @(negedge clk);
            if (fnd_com !== 4'b1110) bad_early = 1'b1;
        end
        vectors++;
        if (bad_early) begin
            miscompares++;
            $display("FAIL reset_first_slot: com=%b seen before first tick, required 1110 only", fnd_com);
        end
    endtask

    task automatic test_static();
        logic [3:0] c;
        logic [7:0] d;
        int len;
        slot_t e;
        count = 14'd1234;
        repeat (SETTLE) @(negedge clk);
        sync_frame();
        push_frame(1234);
        for (int k = 0; k < 4; k++) begin
            capture_slot(c, d, len);
            e = sb.pop_front();
            vectors++;
            if (c !== e.com || d !== e.data) begin
                miscompares++;
                $display("FAIL static_1234 slot%0d: com=%b data=%h required com=%b data=%h", k, c, d, e.com, e.data);
            end
            vectors++;
            if (len != SCAN_DIV) begin
                miscompares++;
                $display("FAIL slot_len slot%0d: %0d cycles required %0d", k, len, SCAN_DIV);
            end
        end
    endtask

    task automatic test_blanking();
        int vals[3] = '{7, 40, 305};
        logic [3:0] c;
        logic [7:0] d;
        int len;
        slot_t e;
        foreach (vals[n]) begin
            count = 14'(vals[n]);
            repeat (SETTLE) @(negedge clk);
            sync_frame();
            push_frame(vals[n]);
            for (int k = 0; k < 4; k++) begin
                capture_slot(c, d, len);
                e = sb.pop_front();
                vectors++;
                if (c !== e.com || d !== e.data) begin
                    miscompares++;
                    $display("FAIL blank_%0d slot%0d: com=%b data=%h required com=%b data=%h", vals[n], k, c, d, e.com, e.data);
                end
            end
        end
    endtask

    task automatic test_clamp_extremes();
        int vals[4] = '{16383, 10000, 9999, 0};
        logic [3:0] c;
        logic [7:0] d;
        int len;
        int frame_len;
        slot_t e;
        foreach (vals[n]) begin
            count = 14'(vals[n]);
            repeat (SETTLE) @(negedge clk);
            sync_frame();
            push_frame(vals[n]);
            frame_len = 0;
            for (int k = 0; k < 4; k++) begin
                capture_slot(c, d, len);
                frame_len += len;
                e = sb.pop_front();
                vectors++;
                if (c !== e.com || d !== e.data) begin
                    miscompares++;
                    $display("FAIL extreme_%0d slot%0d: com=%b data=%h required com=%b data=%h", vals[n], k, c, d, e.com, e.data);
                end
            end
            vectors++;
            if (frame_len != 4 * SCAN_DIV) begin
                miscompares++;
                $display("FAIL frame_len_%0d: %0d cycles required %0d", vals[n], frame_len, 4 * SCAN_DIV);
            end
        end
    endtask

    task automatic test_no_tearing();
        logic [3:0] c;
        logic [7:0] d;
        int len;
        slot_t e;
        count = 14'd1111;
        repeat (SETTLE) @(negedge clk);
        sync_frame();
        push_frame(1111);
        push_frame(2222);
        for (int k = 0; k < 8; k++) begin
            // Change the input once the third slot (idx 2) of the first frame begins.
            if (k == 2) count = 14'd2222;
            capture_slot(c, d, len);
            e = sb.pop_front();
            vectors++;
            if (c !== e.com || d !== e.data) begin
                miscompares++;
                $display("FAIL no_tearing slot%0d: com=%b data=%h required com=%b data=%h", k, c, d, e.com, e.data);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] c;
        logic [7:0] d;
        int len;
        slot_t e;
        // Mid-frame reset while 2222 is shown and digit 2 is active.
        sync_frame();
        capture_slot(c, d, len);
        capture_slot(c, d, len);
        repeat (5) @(negedge clk);
        count = 14'd5678;
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (fnd_com !== 4'b1110 || fnd_data !== 8'hC0) begin
            miscompares++;
            $display("FAIL reset_midframe: com=%b data=%h required com=1110 data=c0", fnd_com, fnd_data);
        end
        reset = 1'b0;
        // The converter is in SHIFT a few cycles after reset release.
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (fnd_com !== 4'b1110 || fnd_data !== 8'hC0) begin
            miscompares++;
            $display("FAIL reset_midshift: com=%b data=%h required com=1110 data=c0", fnd_com, fnd_data);
        end
        repeat (SETTLE) @(negedge clk);
        sync_frame();
        push_frame(5678);
        for (int k = 0; k < 4; k++) begin
            capture_slot(c, d, len);
            e = sb.pop_front();
            vectors++;
            if (c !== e.com || d !== e.data) begin
                miscompares++;
                $display("FAIL after_reset_5678 slot%0d: com=%b data=%h required com=%b data=%h", k, c, d, e.com, e.data);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        count       = '0;
        test_reset();
        test_static();
        test_blanking();
        test_clamp_extremes();
        test_no_tearing();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
